// File: rtl/ipsxe_floating_point_recip_pkg.sv
// Shared definitions for the Newton-Raphson reciprocal sequencer:
// state encoding, exponent bias and per-format iteration constants.
package ipsxe_floating_point_recip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEED_ISSUE = 3'd1,
    ST_SEED_WAIT  = 3'd2,
    ST_ERR_ISSUE  = 3'd3,
    ST_ERR_WAIT   = 3'd4,
    ST_UPD_ISSUE  = 3'd5,
    ST_UPD_WAIT   = 3'd6,
    ST_DONE       = 3'd7
  } recip_state_e;

  // Seed x0 = 24/17 - 8/17 * dn, minimax linear fit of 1/dn on [1,2).
  // Single precision (8,23) encodings, zero-extended to 64 bits.
  localparam logic [63:0] C_24_17_SP    = 64'h0000_0000_3FB4_B4B5;
  localparam logic [63:0] C_NEG_8_17_SP = 64'h0000_0000_BEF0_F0F1;
  localparam logic [63:0] ONE_SP        = 64'h0000_0000_3F80_0000;
  // Double precision (11,52) encodings.
  localparam logic [63:0] C_24_17_DP    = 64'h3FF6_9696_9696_9697;
  localparam logic [63:0] C_NEG_8_17_DP = 64'hBFDE_1E1E_1E1E_1E1E;
  localparam logic [63:0] ONE_DP        = 64'h3FF0_0000_0000_0000;

  // Exponent bias for an ew-bit exponent field.
  function automatic int recip_bias(int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Picks the single-precision constant for 8-bit exponents, double otherwise.
  function automatic logic [63:0] fmt_sel(int ew, logic [63:0] sp, logic [63:0] dp);
    return (ew == 8) ? sp : dp;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_recip_classify_v1_0.sv
// Operand classifier: flags zero (denormals flushed), infinity and NaN,
// and builds the normalised working divisor dn = {0, BIAS, m} in [1,2).
module ipsxe_floating_point_recip_classify_v1_0
  import ipsxe_floating_point_recip_pkg::*;
#(
  parameter int EXP_WIDTH = 11,
  parameter int MAN_WIDTH = 52,
  parameter int W         = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic [W-2:0] d_mag,
  output logic         is_zero,
  output logic         is_inf,
  output logic         is_nan,
  output logic [W-1:0] dn
);

  localparam logic [EXP_WIDTH-1:0] BIAS = EXP_WIDTH'(recip_bias(EXP_WIDTH));

  logic [EXP_WIDTH-1:0] exp_f;
  logic [MAN_WIDTH-1:0] man_f;

  // Field split and class decode of the incoming magnitude.
  always_comb begin
    exp_f   = d_mag[W-2:MAN_WIDTH];
    man_f   = d_mag[MAN_WIDTH-1:0];
    is_zero = (exp_f == '0);
    is_inf  = (&exp_f) && (man_f == '0);
    is_nan  = (&exp_f) && (man_f != '0);
    dn      = {1'b0, BIAS, man_f};
  end

endmodule

// File: rtl/ipsxe_floating_point_recip_nr_ctrl_v1_0.sv
// Newton-Raphson reciprocal sequencer. Drives an external FMA with the
// seed and NR_ITERS error/update pairs, then rescales the exponent.
//
// state         | meaning
// --------------+-----------------------------------------------
// ST_IDLE       | ready for an operand
// ST_SEED_ISSUE | seed op on the FMA bus (o_fma_valid high)
// ST_SEED_WAIT  | waiting for seed result -> x
// ST_ERR_ISSUE  | error op e = 1 - dn*x on the FMA bus
// ST_ERR_WAIT   | waiting for error result -> e
// ST_UPD_ISSUE  | update op x = x + x*e on the FMA bus
// ST_UPD_WAIT   | waiting for update result -> x, maybe finish
// ST_DONE       | o_valid cycle, back to idle next
module ipsxe_floating_point_recip_nr_ctrl_v1_0
  import ipsxe_floating_point_recip_pkg::*;
#(
  parameter int EXP_WIDTH = 11,
  parameter int MAN_WIDTH = 52,
  parameter int NR_ITERS  = 4,
  parameter int W         = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_aclken,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_valid,
  output logic         o_divide_by_zero,
  output logic         o_invalid_op,
  output logic         o_overflow,
  output logic         o_underflow,
  output logic [W-1:0] o_fma_a,
  output logic [W-1:0] o_fma_b,
  output logic [W-1:0] o_fma_c,
  output logic         o_fma_op,
  output logic         o_fma_valid,
  input  logic [W-1:0] i_fma_result,
  input  logic         i_fma_valid
);

  localparam logic [EXP_WIDTH-1:0] BIAS       = EXP_WIDTH'(recip_bias(EXP_WIDTH));
  localparam logic [W-1:0]         C_24_17    = W'(fmt_sel(EXP_WIDTH, C_24_17_SP, C_24_17_DP));
  localparam logic [W-1:0]         C_NEG_8_17 = W'(fmt_sel(EXP_WIDTH, C_NEG_8_17_SP, C_NEG_8_17_DP));
  localparam logic [W-1:0]         ONE        = W'(fmt_sel(EXP_WIDTH, ONE_SP, ONE_DP));
  localparam logic [2:0]           ITER_LAST  = 3'(NR_ITERS - 1);
  localparam logic [W-1:0]         QNAN       = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  recip_state_e          state;
  logic [2:0]            iter_cnt;
  logic [W-1:0]          x_q;
  logic [W-2:0]          dn_mag;
  logic                  s_q;
  logic [EXP_WIDTH-1:0]  ed_q;

  logic                  is_zero, is_inf, is_nan;
  logic [W-1:0]          dn;

  logic [EXP_WIDTH-1:0]  ex;
  logic signed [EXP_WIDTH+1:0] ef;
  logic [W-1:0]          resc_q;
  logic                  resc_uf, resc_of;

  ipsxe_floating_point_recip_classify_v1_0 #(
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_classify (
    .d_mag   (i_d[W-2:0]),
    .is_zero (is_zero),
    .is_inf  (is_inf),
    .is_nan  (is_nan),
    .dn      (dn)
  );

  assign o_fma_op = 1'b0;

  // Exponent rescale of the final x straight off the FMA result bus, so the
  // answer is registered on the same edge that captures the last update.
  always_comb begin
    ex      = i_fma_result[W-2:MAN_WIDTH];
    ef      = $signed({2'b00, ex}) + $signed({2'b00, BIAS}) - $signed({2'b00, ed_q});
    resc_q  = {s_q, ef[EXP_WIDTH-1:0], i_fma_result[MAN_WIDTH-1:0]};
    resc_uf = 1'b0;
    resc_of = 1'b0;
    if (ef[EXP_WIDTH+1] || (ef == '0)) begin
      resc_q  = {s_q, {(W-1){1'b0}}};
      resc_uf = 1'b1;
    end else if (ef >= $signed({2'b00, {EXP_WIDTH{1'b1}}})) begin
      resc_q  = {s_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      resc_of = 1'b1;
    end
  end

  // Sequencer: accept, FMA issue/wait chain, result and flag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      iter_cnt         <= '0;
      x_q              <= '0;
      dn_mag           <= '0;
      s_q              <= 1'b0;
      ed_q             <= '0;
      o_ready          <= 1'b1;
      o_q              <= '0;
      o_valid          <= 1'b0;
      o_divide_by_zero <= 1'b0;
      o_invalid_op     <= 1'b0;
      o_overflow       <= 1'b0;
      o_underflow      <= 1'b0;
      o_fma_a          <= '0;
      o_fma_b          <= '0;
      o_fma_c          <= '0;
      o_fma_valid      <= 1'b0;
    end else if (i_aclken) begin
      o_fma_valid      <= 1'b0;
      o_valid          <= 1'b0;
      o_divide_by_zero <= 1'b0;
      o_invalid_op     <= 1'b0;
      o_overflow       <= 1'b0;
      o_underflow      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            o_ready  <= 1'b0;
            s_q      <= i_d[W-1];
            ed_q     <= i_d[W-2:MAN_WIDTH];
            dn_mag   <= dn[W-2:0];
            iter_cnt <= ITER_LAST;
            if (is_nan) begin
              o_q          <= QNAN;
              o_invalid_op <= 1'b1;
              o_valid      <= 1'b1;
              state        <= ST_DONE;
            end else if (is_inf) begin
              o_q     <= {i_d[W-1], {(W-1){1'b0}}};
              o_valid <= 1'b1;
              state   <= ST_DONE;
            end else if (is_zero) begin
              o_q              <= {i_d[W-1], {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
              o_divide_by_zero <= 1'b1;
              o_valid          <= 1'b1;
              state            <= ST_DONE;
            end else begin
              o_fma_a     <= dn;
              o_fma_b     <= C_NEG_8_17;
              o_fma_c     <= C_24_17;
              o_fma_valid <= 1'b1;
              state       <= ST_SEED_ISSUE;
            end
          end
        end
        ST_SEED_ISSUE: state <= ST_SEED_WAIT;
        ST_SEED_WAIT: begin
          if (i_fma_valid) begin
            x_q         <= i_fma_result;
            o_fma_a     <= {1'b1, dn_mag};
            o_fma_b     <= i_fma_result;
            o_fma_c     <= ONE;
            o_fma_valid <= 1'b1;
            state       <= ST_ERR_ISSUE;
          end
        end
        ST_ERR_ISSUE: state <= ST_ERR_WAIT;
        ST_ERR_WAIT: begin
          if (i_fma_valid) begin
            o_fma_a     <= x_q;
            o_fma_b     <= i_fma_result;
            o_fma_c     <= x_q;
            o_fma_valid <= 1'b1;
            state       <= ST_UPD_ISSUE;
          end
        end
        ST_UPD_ISSUE: state <= ST_UPD_WAIT;
        ST_UPD_WAIT: begin
          if (i_fma_valid) begin
            x_q <= i_fma_result;
            if (iter_cnt == '0) begin
              o_q         <= resc_q;
              o_underflow <= resc_uf;
              o_overflow  <= resc_of;
              o_valid     <= 1'b1;
              state       <= ST_DONE;
            end else begin
              iter_cnt    <= iter_cnt - 3'd1;
              o_fma_a     <= {1'b1, dn_mag};
              o_fma_b     <= i_fma_result;
              o_fma_c     <= ONE;
              o_fma_valid <= 1'b1;
              state       <= ST_ERR_ISSUE;
            end
          end
        end
        ST_DONE: begin
          o_ready <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
